// File: rtl/checkpoint_reporter_if.sv
// checkpoint_reporter_if: Wishbone classic slave bus bundle for checkpoint_reporter
interface checkpoint_reporter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/checkpoint_reporter.sv
// checkpoint_reporter: queues firmware checkpoint codes and holds each on the pads for a minimum time; CHECKPOINT_LA_MIRROR_EN adds la_data_out
module checkpoint_reporter #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    checkpoint_reporter_if.slave wbs,
    output logic [15:0]          io_out,
`ifdef CHECKPOINT_LA_MIRROR_EN
    output logic [15:0]          la_data_out,
`endif
    output logic [15:0]          io_oeb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW:0]   wr_ptr, rd_ptr, fill;
    logic [15:0]   mem [FIFO_DEPTH];
    logic          empty, full, pop, acc, hit, wr_code, wr_ctrl, push;
    logic          en, overflow, ack_q;
    logic [31:0]   dat_q, fill_w, status, rdata;
    logic [2:0]    fill_sat;
    logic          unused_bits;

    assign acc      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
    assign hit      = wbs.wbs_adr_i[31:3] == BASE_ADDR[31:3];
    assign wr_code  = acc & hit & wbs.wbs_we_i & ~wbs.wbs_adr_i[2] & (wbs.wbs_sel_i[1:0] == 2'b11);
    assign wr_ctrl  = acc & hit & wbs.wbs_we_i & wbs.wbs_adr_i[2];
    // a push into a full queue still lands when the display pops in the same cycle
    assign push     = wr_code & (~full | pop);
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill     = wr_ptr - rd_ptr;
    assign fill_w   = {{(31 - AW){1'b0}}, fill};
    assign fill_sat = fill_w > 32'd7 ? 3'd7 : fill_w[2:0];
    assign status   = {24'b0, overflow, state == ST_HOLD, full, empty, 1'b0, fill_sat};
    assign rdata    = wbs.wbs_adr_i[2] ? {31'b0, en} : status;
    assign io_oeb   = ~{16{en}};
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign unused_bits   = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};
`ifdef CHECKPOINT_LA_MIRROR_EN
    assign la_data_out = io_out;
`endif

    // single-cycle ack, read data captured with it, control register and sticky overflow
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'b0;
            en       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ack_q <= acc & hit;
            dat_q <= (acc & hit & ~wbs.wbs_we_i) ? rdata : 32'b0;
            if (wr_code & full & ~pop) overflow <= 1'b1;
            if (wr_ctrl) begin
                en <= wbs.wbs_dat_i[0];
                if (wbs.wbs_dat_i[1]) overflow <= 1'b0;
            end
        end
    end

    // queue pointers; wrap naturally with the extra MSB distinguishing full from empty
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // queue storage needs no reset; the pointers define what is valid
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wbs.wbs_dat_i[15:0];
    end

    // display state, hold counter and the code on the pads
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            io_out <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pop) io_out <= mem[rd_ptr[AW-1:0]];
        end
    end

    // pop when idle with work queued, or when the current hold has expired
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        if (state == ST_IDLE) begin
            if (!empty) begin
                pop       = 1'b1;
                cnt_nxt   = HOLD_LOAD;
                state_nxt = ST_HOLD;
            end
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
        end else if (!empty) begin
            pop     = 1'b1;
            cnt_nxt = HOLD_LOAD;
        end else begin
            state_nxt = ST_IDLE;
        end
    end
endmodule

// File: doc/checkpoint_reporter.md
# checkpoint_reporter

Wishbone-slave block inside the user project that turns firmware checkpoint writes into stable 16-bit codes on `mprj_io[31:16]`, the pins the Caravel testbench monitors for pass/fail codes such as 16'hAB60 and 16'hAB61. Firmware writes codes back-to-back. The block queues them in a small FIFO and holds each code on the pads for a guaranteed minimum number of clocks, so the bench monitor never misses a short-lived value.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: code queue depth; power of two, ≥2.
- `HOLD_CYCLES`, default 16: minimum clocks each code is driven; ≥1.
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base address. Decode uses `wbs_adr_i[31:3]`.

Ports:
- `wb_clk_i`  in  1: the single clock.
- `wb_rst_i`  in  1: asynchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each: Wishbone classic strobes.
- `wbs_sel_i`  in  4: byte selects. Only the 16-bit CODE write requires `sel[1:0]==2'b11`; otherwise the write is ignored but still acked.
- `wbs_adr_i`  in  32: address.
- `wbs_dat_i`  in  32: write data.
- `wbs_ack_o`  out  1: acknowledge.
- `wbs_dat_o`  out  32: read data.
- `io_out`  out  16: code driven to `mprj_io[31:16]`.
- `io_oeb`  out  16: active-low output enables.
- `la_data_out`  out  16: only present with `CHECKPOINT_LA_MIRROR_EN`.

## Operation
- Register map, by offset:
  - 0x0 CODE: write pushes `dat_i[15:0]`. Read returns STATUS: {16'b0, 8'b0, overflow, busy, full, empty, 1'b0, count[2:0]}. `count` saturates at 7 for larger depths.
  - 0x4 CTRL:
    - bit0 `en`: drive enable. `io_oeb = ~{16{en}}`.
    - bit1: write 1 clears `overflow`; self-clearing.
    - Read returns {30'b0, 1'b0, en}.
- Push while full: data dropped, `overflow` set (sticky), access still acked.
- Display FSM states:
  - IDLE: FIFO empty and hold expired. `io_out` keeps the last code indefinitely.
  - HOLD: counter running. `busy=1`.
  - Transitions:
    - IDLE with FIFO non-empty → pop, load counter with `HOLD_CYCLES-1`, go to HOLD.
    - HOLD with counter==0 and FIFO non-empty → pop and reload, stay in HOLD.
    - HOLD with counter==0 and FIFO empty → IDLE.
- No bypass path: a pushed code always passes through the FIFO.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are derived from pointer MSB and index equality.
- Simultaneous push and pop:
  - When full: both occur, count unchanged, no overflow.
  - When empty: impossible, because a pop requires non-empty at the sampling edge.
- Reset (async, any time, including mid-hold or mid-access):
  - `io_out=0`, `io_oeb=16'hFFFF`, `wbs_ack_o=0`, `wbs_dat_o=0`.
  - FIFO empty, `en=0`, `overflow=0`, FSM=IDLE, counter=0.

## Timing
- Wishbone access, with the edge where `cyc&stb&!ack` is sampled as E0:
  - `wbs_ack_o` is high for exactly the cycle after E0, with no wait states.
  - `wbs_dat_o` is valid during ack.
  - The push happens at E0.
  - Back-to-back strobes give ack every other cycle.
- Latency: the pop happens at E1, so `io_out` shows the code after E1 (2 clocks from strobe sample).
- Each code stays on `io_out` for exactly `HOLD_CYCLES` clocks when the next code is queued. Otherwise it stays until the next push.
- `io_oeb` changes one cycle after the CTRL write is sampled.

## Configuration
- `CHECKPOINT_LA_MIRROR_EN`:
  - Defined: port `la_data_out[15:0]` exists and equals `io_out` combinationally, regardless of `en`.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then read STATUS → `0x0000_0010` (empty=1), `io_oeb=16'hFFFF`, `io_out=0`.
- Write CTRL=1, then CODE=0xAB60 → `io_oeb=0`; `io_out=0xAB60` 2 clocks after the strobe sample; STATUS busy=1 for 16 clocks, then 0; `io_out` stays 0xAB60.
- Write 0xAB60 and 0xAB61 back-to-back → `io_out` is 0xAB60 for exactly 16 clocks, then 0xAB61.
- With `en=1`, write 6 codes while the first is holding (FIFO_DEPTH=4) → 1 code displayed, 4 queued, 1 dropped; `overflow=1`; the display sequence omits the 6th code; CTRL bit1 write → `overflow=0`.
- Assert `wb_rst_i` mid-hold with 2 codes queued → all outputs return to reset values immediately without a clock edge; STATUS afterwards reads empty.
- With `CHECKPOINT_LA_MIRROR_EN` and `en=0`, write 0x1234 → `la_data_out=0x1234`, `io_oeb=16'hFFFF`.
